// File: rtl/input_cond_pkg.sv
// Shared types and helpers for the input_conditioner front end.
package input_cond_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } btn_state_e;

  // Counter must be able to hold DEBOUNCE_CYCLES itself.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// Multi-flop synchroniser followed by a whole-word debouncer.
// accept pulses on the edge where the debounced word takes a new value.
module debounce_sync #(
  parameter int WIDTH           = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] db,
  output logic             accept
);
  import input_cond_pkg::*;

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] db_q, db_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    sync_d[0] = raw;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // A mismatch must persist for DEBOUNCE_CYCLES edges; the word present
  // on the final edge is the one accepted, even if it changed mid-count.
  always_comb begin
    db_d   = db_q;
    cnt_d  = '0;
    accept = 1'b0;
    if (sync_q[SYNC_STAGES-1] != db_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        db_d   = sync_q[SYNC_STAGES-1];
        accept = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      db_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign db = db_q;

endmodule

// File: rtl/input_conditioner.sv
// Start button / select switch front end: sync, debounce, one-shot start, select freeze.
// Optional AUTO_START_ON_SEL_EN: a settled select change while idle also issues a start.
module input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SEL_W           = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             btn_start_raw,
  input  logic [SEL_W-1:0] sw_digit_raw,
  input  logic [SEL_W-1:0] sw_img_raw,
  input  logic             done_in,
  output logic             start_pulse,
  output logic [SEL_W-1:0] digit_sel,
  output logic [SEL_W-1:0] img_sel,
  output logic             sel_locked
);
  import input_cond_pkg::*;

  logic             btn_db, btn_acc, digit_acc, img_acc;
  logic [SEL_W-1:0] digit_db, img_db;

  debounce_sync #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
    u_btn (.clock(clock), .reset(reset), .raw(btn_start_raw), .db(btn_db), .accept(btn_acc));

  debounce_sync #(.WIDTH(SEL_W), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
    u_digit (.clock(clock), .reset(reset), .raw(sw_digit_raw), .db(digit_db), .accept(digit_acc));

  debounce_sync #(.WIDTH(SEL_W), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
    u_img (.clock(clock), .reset(reset), .raw(sw_img_raw), .db(img_db), .accept(img_acc));

  btn_state_e       state_q, state_d;
  logic             pulse_q, pulse_d;
  logic             run_q, run_d;
  logic             done_dly_q;
  logic [SEL_W-1:0] digit_sel_q, digit_sel_d, img_sel_q, img_sel_d;
  logic             btn_rise, btn_fall, done_rise, auto_req, unused_acc;

  // Button edges are seen on the same edge the debounced level changes.
  assign btn_rise   = btn_acc & ~btn_db;
  assign btn_fall   = btn_acc & btn_db;
  assign done_rise  = done_in & ~done_dly_q;
  assign unused_acc = digit_acc | img_acc;

`ifdef AUTO_START_ON_SEL_EN
  logic sel_upd_q, sel_upd_d;

  // Flags the edge on which the idle select outputs take a new value.
  always_comb begin
    sel_upd_d = ~run_q && ((digit_db != digit_sel_q) || (img_db != img_sel_q));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sel_upd_q <= 1'b0;
    end else begin
      sel_upd_q <= sel_upd_d;
    end
  end

  assign auto_req = sel_upd_q;
`else
  assign auto_req = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pulse_d     = 1'b0;
    run_d       = run_q;
    digit_sel_d = digit_sel_q;
    img_sel_d   = img_sel_q;

    case (state_q)
      IDLE: if (btn_rise) state_d = HELD;
      HELD: if (btn_fall) state_d = IDLE;
    endcase

    // A done edge beats a coincident press, which is then simply consumed.
    if (((state_q == IDLE) && btn_rise || auto_req) && !run_q && !done_rise) begin
      pulse_d = 1'b1;
    end

    if (done_rise) begin
      run_d = 1'b0;
    end else if (pulse_d) begin
      run_d = 1'b1;
    end

    if (!run_q) begin
      digit_sel_d = digit_db;
      img_sel_d   = img_db;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pulse_q     <= 1'b0;
      run_q       <= 1'b0;
      done_dly_q  <= 1'b0;
      digit_sel_q <= '0;
      img_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      pulse_q     <= pulse_d;
      run_q       <= run_d;
      done_dly_q  <= done_in;
      digit_sel_q <= digit_sel_d;
      img_sel_q   <= img_sel_d;
    end
  end

  assign start_pulse = pulse_q;
  assign sel_locked  = run_q;
  assign digit_sel   = digit_sel_q;
  assign img_sel     = img_sel_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=8) with a
// behavioural model checked every cycle plus hand-computed literal checks.
module tb_input_conditioner;

  localparam int SYNC = 2;
  localparam int DC   = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       btn_raw;
  logic [3:0] dig_raw, img_raw;
  logic       done_in;
  logic       start_pulse, sel_locked;
  logic [3:0] digit_sel, img_sel;

  int tests = 0;
  int fails = 0;
  int edge_no = 0;
  int pulse_total = 0;
  int last_pulse_edge = -1;
  int base, p0;

  input_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC), .SEL_W(4)) dut (
    .clock(clock), .reset(reset), .btn_start_raw(btn_raw),
    .sw_digit_raw(dig_raw), .sw_img_raw(img_raw), .done_in(done_in),
    .start_pulse(start_pulse), .digit_sel(digit_sel), .img_sel(img_sel),
    .sel_locked(sel_locked)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_no++;

  always @(negedge clock) begin
    if (start_pulse === 1'b1) begin
      pulse_total++;
      last_pulse_edge = edge_no;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic btn, input logic [3:0] dig, input logic [3:0] img,
                               input logic done, input int n);
    btn_raw = btn;
    dig_raw = dig;
    img_raw = img;
    done_in = done;
    step(n);
  endtask

  // Model: a raw word is seen SYNC edges after it is sampled; a debounced word
  // changes once it has differed from the seen word for DC consecutive edges.
  // Start = debounced button rising while no run and no done edge.
  logic [11:0] m_hist[$];
  logic [3:0]  m_db [3];
  int          m_streak [3];
  logic        m_run, m_pulse, m_done_prev;
  logic [3:0]  m_dsel, m_isel;
  logic [11:0] t_synced;
  logic [3:0]  t_old [3];
  logic        t_rise, t_done_rise;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_hist.delete();
      for (int i = 0; i < 3; i++) begin
        m_db[i] = '0;
        m_streak[i] = 0;
      end
      m_run = 1'b0;
      m_pulse = 1'b0;
      m_done_prev = 1'b0;
      m_dsel = '0;
      m_isel = '0;
    end else begin
      m_hist.push_front({img_raw, dig_raw, 3'b000, btn_raw});
      if (m_hist.size() > SYNC + 1) void'(m_hist.pop_back());
      t_synced = (m_hist.size() == SYNC + 1) ? m_hist[SYNC] : 12'h000;
      for (int i = 0; i < 3; i++) begin
        t_old[i] = m_db[i];
        if (t_synced[i*4 +: 4] == m_db[i]) begin
          m_streak[i] = 0;
        end else begin
          m_streak[i]++;
          if (m_streak[i] == DC) begin
            m_db[i] = t_synced[i*4 +: 4];
            m_streak[i] = 0;
          end
        end
      end
      t_rise = !t_old[0][0] && m_db[0][0];
      t_done_rise = done_in && !m_done_prev;
      m_done_prev = done_in;
      if (!m_run) begin
        m_dsel = t_old[1];
        m_isel = t_old[2];
      end
      m_pulse = t_rise && !m_run && !t_done_rise;
      if (t_done_rise) m_run = 1'b0;
      else if (m_pulse) m_run = 1'b1;
    end
  end

  always @(negedge clock) begin
    checkOutput("start_pulse", 32'(start_pulse), 32'(m_pulse));
    checkOutput("sel_locked", 32'(sel_locked), 32'(m_run));
    checkOutput("digit_sel", 32'(digit_sel), 32'(m_dsel));
    checkOutput("img_sel", 32'(img_sel), 32'(m_isel));
  end

  initial begin
    reset = 1'b0;
    btn_raw = 1'b0;
    dig_raw = '0;
    img_raw = '0;
    done_in = 1'b0;
    step(3);
    checkOutput("rst_pulse", 32'(start_pulse), 0);
    checkOutput("rst_locked", 32'(sel_locked), 0);
    checkOutput("rst_digit", 32'(digit_sel), 0);
    checkOutput("rst_img", 32'(img_sel), 0);
    reset = 1'b1;

    applyStimulus(1'b0, 4'h3, 4'h5, 1'b0, 12);
    checkOutput("init_digit", 32'(digit_sel), 3);
    checkOutput("init_img", 32'(img_sel), 5);

    // Clean press
    base = edge_no; p0 = pulse_total;
    applyStimulus(1'b1, 4'h3, 4'h5, 1'b0, 30);
    checkOutput("clean_count", 32'(pulse_total - p0), 1);
    checkOutput("clean_edge", 32'(last_pulse_edge - base), 10);
    checkOutput("clean_locked", 32'(sel_locked), 1);

    // Selects frozen during the run, released one cycle after the done edge
    applyStimulus(1'b1, 4'h7, 4'h5, 1'b0, 15);
    checkOutput("locked_digit", 32'(digit_sel), 3);
    applyStimulus(1'b0, 4'h7, 4'h5, 1'b0, 12);
    applyStimulus(1'b0, 4'h7, 4'h5, 1'b1, 1);
    checkOutput("done_unlock", 32'(sel_locked), 0);
    checkOutput("done_digit_hold", 32'(digit_sel), 3);
    step(1);
    checkOutput("done_digit_new", 32'(digit_sel), 7);
    applyStimulus(1'b0, 4'h7, 4'h5, 1'b0, 2);

    // Press during a run is consumed
    p0 = pulse_total;
    applyStimulus(1'b1, 4'h7, 4'h5, 1'b0, 30);
    checkOutput("run2_count", 32'(pulse_total - p0), 1);
    applyStimulus(1'b0, 4'h7, 4'h5, 1'b0, 12);
    p0 = pulse_total;
    applyStimulus(1'b1, 4'h7, 4'h5, 1'b0, 15);
    checkOutput("inrun_count", 32'(pulse_total - p0), 0);
    applyStimulus(1'b0, 4'h7, 4'h5, 1'b0, 12);
    applyStimulus(1'b0, 4'h7, 4'h5, 1'b1, 2);
    applyStimulus(1'b0, 4'h7, 4'h5, 1'b0, 2);
    base = edge_no; p0 = pulse_total;
    applyStimulus(1'b1, 4'h7, 4'h5, 1'b0, 15);
    checkOutput("repress_count", 32'(pulse_total - p0), 1);
    checkOutput("repress_edge", 32'(last_pulse_edge - base), 10);

    // Done edge coincident with the debounced press
    applyStimulus(1'b0, 4'h7, 4'h5, 1'b0, 12);
    applyStimulus(1'b0, 4'h7, 4'h5, 1'b1, 2);
    applyStimulus(1'b0, 4'h7, 4'h5, 1'b0, 2);
    p0 = pulse_total;
    applyStimulus(1'b1, 4'h7, 4'h5, 1'b0, 9);
    applyStimulus(1'b1, 4'h7, 4'h5, 1'b1, 1);
    checkOutput("simul_pulse", 32'(start_pulse), 0);
    checkOutput("simul_locked", 32'(sel_locked), 0);
    applyStimulus(1'b1, 4'h7, 4'h5, 1'b0, 10);
    checkOutput("simul_count", 32'(pulse_total - p0), 0);

    // Bouncing button, settles high after the write at relative edge 18
    applyStimulus(1'b0, 4'h7, 4'h5, 1'b0, 12);
    base = edge_no; p0 = pulse_total;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(((i / 3) % 2) == 0, 4'h7, 4'h5, 1'b0, 1);
    end
    applyStimulus(1'b1, 4'h7, 4'h5, 1'b0, 15);
    checkOutput("bounce_count", 32'(pulse_total - p0), 1);
    checkOutput("bounce_edge", 32'(last_pulse_edge - base), 28);

    // Reset mid-run with the image debouncer part-way through a count
    applyStimulus(1'b1, 4'h7, 4'h9, 1'b0, 5);
    checkOutput("pre_rst_locked", 32'(sel_locked), 1);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_pulse", 32'(start_pulse), 0);
    checkOutput("mid_rst_locked", 32'(sel_locked), 0);
    checkOutput("mid_rst_digit", 32'(digit_sel), 0);
    checkOutput("mid_rst_img", 32'(img_sel), 0);
    step(3);
    reset = 1'b1;
    base = edge_no; p0 = pulse_total;
    applyStimulus(1'b1, 4'h7, 4'h9, 1'b0, 15);
    checkOutput("post_rst_count", 32'(pulse_total - p0), 1);
    checkOutput("post_rst_edge", 32'(last_pulse_edge - base), 10);
    checkOutput("post_rst_digit", 32'(digit_sel), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front-end stage feeding the design's start/select inputs.
- Synchronises and debounces the raw board start button and the digit/image select switches, then produces a single-cycle start pulse.
- Freezes the select buses while a classification run is in flight; the run is bounded by the start pulse and the rising edge of done.
- Sits between the board pins and the processing top; runs on the generated system clock domain.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser (≥2).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new level (10 ms at 100 MHz, ≥1).
- SEL_W, 4, width of each select bus.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- btn_start_raw  in  1  raw start pushbutton, asynchronous, active-high.
- sw_digit_raw  in  SEL_W  raw digit-select switches, asynchronous.
- sw_img_raw  in  SEL_W  raw image-select switches, asynchronous.
- done_in  in  1  done level from the processing top.
- start_pulse  out  1  one-cycle start request to the processing top.
- digit_sel  out  SEL_W  debounced digit select, frozen during a run.
- img_sel  out  SEL_W  debounced image select, frozen during a run.
- sel_locked  out  1  high while a run is in flight (run flag).

Behaviour:
- Reset (asynchronous assert, synchronous release by the driving logic):
  - All synchroniser flops, debounced levels and counters are 0.
  - start_pulse=0, digit_sel=0, img_sel=0, sel_locked=0, FSM=IDLE.
- Synchronisers: each raw input passes through SYNC_STAGES flops. Buses are synchronised bitwise, then debounced as a whole word.
- Debouncer, one instance per input: btn, digit bus, img bus.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - If sync==db, cnt<=0.
  - Otherwise cnt increments. When cnt==DEBOUNCE_CYCLES-1, db<=sync and cnt<=0 on the same edge.
  - Any mid-count change of the synced word back to db clears cnt. A change to a third value keeps counting; acceptance takes the value present at the final edge.
  - Latency: a clean raw edge is reflected in db after SYNC_STAGES+DEBOUNCE_CYCLES clock edges.
- Button FSM:
  - IDLE: on db_btn rising, go to HELD. Assert start_pulse on that same edge only if run==0.
  - HELD: wait for db_btn==0, then return to IDLE. No further pulse while held (no auto-repeat).
- start_pulse:
  - Registered output, high exactly one cycle.
  - Never asserted while run==1. A press during a run is consumed, not queued.
- Run flag (sel_locked):
  - Set on the cycle start_pulse is asserted.
  - Cleared on the rising edge of done_in, detected with a registered done_in delay flop.
  - If done_in rises on the same cycle db_btn rises, the clear wins and that press is consumed with no pulse.
- Select outputs:
  - While run==0, digit_sel/img_sel <= debounced buses each cycle.
  - On the start_pulse cycle they capture the current debounced buses; this is the value presented with the pulse.
  - Held constant while run==1.
  - Switch changes during a run are still debounced and appear on the first cycle after run clears.
- done_in held high across runs: only a rising edge clears run. The processing top is required to drop done on start.

Optional Feature:
- Macro: AUTO_START_ON_SEL_EN.
- Defined:
  - When run==0 and either debounced select bus changes value, a start_pulse is issued on the cycle after the outputs update, with the same run-flag semantics.
  - A simultaneous button pulse and select change produce one pulse only.
- Undefined: starts come only from the button.

Decomposition:
- Shared package input_cond_pkg: localparam-derived counter width function and the FSM state enum (IDLE, HELD).
- One natural sub-module: debounce_sync, parameterised by width, SYNC_STAGES and DEBOUNCE_CYCLES; instantiated three times.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=8):
- Clean press: raw btn 0→1 at cycle 0, held 30 cycles → start_pulse high exactly at edge 10, sel_locked=1 from edge 10; a single pulse only.
- Bounce: btn toggles every 3 cycles for 20 cycles, then settles high → no pulse during bouncing; one pulse 10 edges after the final settle.
- Locked selects: digit=4'h3 at start; change raw digit to 4'h7 mid-run → digit_sel stays 3. Pulse done_in high → digit_sel=7 on the first cycle after sel_locked drops.
- Press during run: second press while sel_locked=1 → no pulse. Release and re-press after done rises → pulse.
- Simultaneous: db_btn rise aligned with the done_in rising edge → no pulse, sel_locked=0, FSM in HELD.
- Reset mid-run: assert reset with sel_locked=1 and cnt partially counted → all outputs 0 immediately; after release, a held button produces a pulse 10 edges later.
